// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one single-port memory between instruction fetch and
// MEM-stage data access of a pipelined MIPS core. Within each pipeline step
// the data access is served first, then the fetch; the pipeline is stalled
// until both are done. A watchdog abandons accesses that never complete.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instReq,
    input  logic [31:0] instMemAddress,
    output logic [31:0] instruction,
    input  logic        dataMemRead,
    input  logic        dataMemWrite,
    input  logic [31:0] dataMemAddress,
    input  logic [31:0] dataMemWriteData,
    output logic [31:0] dataMemReadData,
    output logic        stall,
    output logic        memReq,
    output logic        memRead,
    output logic        memWrite,
    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    input  logic        memAck,
    input  logic [31:0] memRData,
    output logic        busError
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWAIT = 2'd1,
        IWAIT = 2'd2
    } state_t;

    // The counter starts at 0 on the issue edge, so the abandon edge comes
    // TIMEOUT edges after issue when the limit is TIMEOUT-1.
    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);

    state_t      state, state_d;
    logic        data_need, inst_need;
    logic        data_done, data_done_d;
    logic        inst_done, inst_done_d;
    logic        mem_req_d, mem_read_d, mem_write_d;
    logic [31:0] mem_addr_d, mem_wdata_d;
    logic [31:0] instruction_d, read_data_d;
    logic [15:0] wd_cnt, wd_cnt_d;
    logic        bus_error_d;
    logic        wd_expired;
    logic        ack;
    logic [31:0] ack_data;

    assign data_need  = dataMemRead | dataMemWrite;
    assign inst_need  = instReq;
    assign stall      = (data_need & ~data_done) | (inst_need & ~inst_done);

    // A watchdog expiry behaves like an ack that returns zero (a NOP fetch).
    assign wd_expired = (wd_cnt == WD_LIMIT);
    assign ack        = memAck | wd_expired;
    assign ack_data   = memAck ? memRData : 32'h0;

    // Next-state and next-register logic for the access sequencer.
    always_comb begin
        // NOTE: every signal gets a hold-value default first so no path through
        // the case statement leaves one unassigned and infers a latch.
        state_d       = state;
        data_done_d   = data_done;
        inst_done_d   = inst_done;
        mem_req_d     = memReq;
        mem_read_d    = memRead;
        mem_write_d   = memWrite;
        mem_addr_d    = memAddr;
        mem_wdata_d   = memWData;
        instruction_d = instruction;
        read_data_d   = dataMemReadData;
        wd_cnt_d      = wd_cnt;
        bus_error_d   = busError;

        // Step boundary: the pipeline advances on this edge, so the next
        // step starts with nothing served.
        if (!stall) begin
            data_done_d = 1'b0;
            inst_done_d = 1'b0;
        end

        case (state)
            IDLE: begin
                mem_req_d = 1'b0;
                if (data_need && !data_done) begin
                    mem_req_d   = 1'b1;
                    mem_addr_d  = dataMemAddress;
                    mem_wdata_d = dataMemWriteData;
                    mem_write_d = dataMemWrite;
                    mem_read_d  = dataMemRead & ~dataMemWrite;
                    wd_cnt_d    = 16'd0;
                    state_d     = DWAIT;
                end else if (inst_need && !inst_done) begin
                    mem_req_d   = 1'b1;
                    mem_addr_d  = instMemAddress;
                    mem_read_d  = 1'b1;
                    mem_write_d = 1'b0;
                    wd_cnt_d    = 16'd0;
                    state_d     = IWAIT;
                end
            end

            DWAIT: begin
                if (ack) begin
                    if (memRead) read_data_d = ack_data;
                    if (!memAck) bus_error_d = 1'b1;
                    data_done_d = 1'b1;
                    if (inst_need && !inst_done) begin
                        // Back-to-back fetch: memReq stays high.
                        mem_req_d   = 1'b1;
                        mem_addr_d  = instMemAddress;
                        mem_read_d  = 1'b1;
                        mem_write_d = 1'b0;
                        wd_cnt_d    = 16'd0;
                        state_d     = IWAIT;
                    end else begin
                        mem_req_d = 1'b0;
                        state_d   = IDLE;
                    end
                end else begin
                    wd_cnt_d = wd_cnt + 16'd1;
                end
            end

            IWAIT: begin
                if (ack) begin
                    instruction_d = ack_data;
                    if (!memAck) bus_error_d = 1'b1;
                    inst_done_d   = 1'b1;
                    mem_req_d     = 1'b0;
                    state_d       = IDLE;
                end else begin
                    wd_cnt_d = wd_cnt + 16'd1;
                end
            end

            default: begin
                mem_req_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and output registers; reset overrides any pending ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            data_done       <= 1'b0;
            inst_done       <= 1'b0;
            memReq          <= 1'b0;
            memRead         <= 1'b0;
            memWrite        <= 1'b0;
            memAddr         <= 32'h0;
            memWData        <= 32'h0;
            instruction     <= 32'h0;
            dataMemReadData <= 32'h0;
            wd_cnt          <= 16'd0;
            busError        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state           <= state_d;
            data_done       <= data_done_d;
            inst_done       <= inst_done_d;
            memReq          <= mem_req_d;
            memRead         <= mem_read_d;
            memWrite        <= mem_write_d;
            memAddr         <= mem_addr_d;
            memWData        <= mem_wdata_d;
            instruction     <= instruction_d;
            dataMemReadData <= read_data_d;
            wd_cnt          <= wd_cnt_d;
            busError        <= bus_error_d;
        end
    end

endmodule
